// File: rtl/wb_ufp_timeout_slice.sv
// Registered Wishbone classic slice between the management UFP and the bus bridge, with a downstream watchdog.
// Latency: request captured on one edge, wbm_stb_o high after it, wbs_ack_o one cycle after the downstream ack (3-cycle minimum).
// Backpressure: one transfer in flight; the UFP waits on wbs_ack_o, and a silent downstream is cut off after TIMEOUT_CYCLES.
// Optional build macro WB_SLICE_ERR_EN: adds wbs_err_o and reports timeouts on it instead of wbs_ack_o.
module wb_ufp_timeout_slice #(
    parameter int unsigned  TIMEOUT_CYCLES = 64,
    parameter logic [31:0]  TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    output logic [31:0] wbm_adr_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        timeout_o,
    output logic [7:0]  timeout_count_o
`ifdef WB_SLICE_ERR_EN
    ,
    output logic        wbs_err_o
`endif
);

    localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           stb_q, stb_d;
    logic           we_q, we_d;
    logic [3:0]     sel_q, sel_d;
    logic [31:0]    dat_q, dat_d;
    logic [31:0]    adr_q, adr_d;
    logic           ack_q, ack_d;
    logic [31:0]    rdat_q, rdat_d;
    logic           to_q, to_d;
    logic [7:0]     tcnt_q, tcnt_d;
`ifdef WB_SLICE_ERR_EN
    logic           err_q, err_d;
`endif

    // Next-state and next-register values; ack beats timeout, abort beats both.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        adr_d   = adr_q;
        ack_d   = 1'b0;
        rdat_d  = rdat_q;
        to_d    = to_q;
        tcnt_d  = tcnt_q;
`ifdef WB_SLICE_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    dat_d   = wbs_dat_i;
                    adr_d   = wbs_adr_i;
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!wbs_cyc_i) begin
                    stb_d   = 1'b0;
                    state_d = IDLE;
                end else if (wbm_ack_i) begin
                    rdat_d  = wbm_dat_i;
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdat_d  = TIMEOUT_DATA;
                    stb_d   = 1'b0;
                    to_d    = 1'b1;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
`ifdef WB_SLICE_ERR_EN
                    err_d   = 1'b1;
`else
                    ack_d   = 1'b1;
`endif
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transfer silently.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            dat_q   <= 32'h0;
            adr_q   <= 32'h0;
            ack_q   <= 1'b0;
            rdat_q  <= 32'h0;
            to_q    <= 1'b0;
            tcnt_q  <= 8'h0;
`ifdef WB_SLICE_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            adr_q   <= adr_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            to_q    <= to_d;
            tcnt_q  <= tcnt_d;
`ifdef WB_SLICE_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign wbs_ack_o       = ack_q;
    assign wbs_dat_o       = rdat_q;
    assign wbm_stb_o       = stb_q;
    assign wbm_cyc_o       = stb_q;
    assign wbm_we_o        = we_q;
    assign wbm_sel_o       = sel_q;
    assign wbm_dat_o       = dat_q;
    assign wbm_adr_o       = adr_q;
    assign timeout_o       = to_q;
    assign timeout_count_o = tcnt_q;
`ifdef WB_SLICE_ERR_EN
    assign wbs_err_o       = err_q;
`endif

endmodule
